tm1638_key_reader: RTL
======================

Name: tm1638_key_reader

Overview:
- Reads the 8 push-buttons of a TM1638 board. This is the input direction of the same board whose LED row is driven by the LED pattern blocks.
- Each scan is triggered by a start pulse, typically a TickGen tick. A scan runs one serial frame: STB low, send read-key command 0x42, wait, clock in 4 scan bytes, STB high.
- The scan bytes are decoded into a key vector and presented with a one-cycle valid strobe. The bidirectional DIO pin is split into out/oe/in; the tristate buffer sits at the top level.

Parameters:
- HALF_PER, 25, system clocks per half period of SCLK (50 MHz / (2*25) = 1 MHz). Legal range is 1 or more.
- WAIT_CYC, 100, system clocks between the last command rising edge and the first read falling edge (2 us at 50 MHz, TM1638 Twait ≥ 1 us). Legal range is 1 or more.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  scan request, one-cycle pulse. Ignored while busy=1.
- dio_in  in  1  DIO pad input, already synchronised at the top level.
- stb  out  1  TM1638 STB, active low.
- sclk  out  1  TM1638 CLK. Idles high.
- dio_out  out  1  value driven onto DIO when dio_oe=1.
- dio_oe  out  1  1 = block drives DIO; 0 = released (pull-up, or TM1638 drives it).
- busy  out  1  high from the cycle after start is accepted until valid is asserted.
- keys  out  8  debounced-by-scan key state, 1 = pressed. keys[i] is button S(i+1).
- raw  out  32  last scan bytes {byte3,byte2,byte1,byte0}.
- valid  out  1  one-cycle pulse; keys and raw were updated this cycle.

Behaviour:
- Reset values: stb=1, sclk=1, dio_out=1, dio_oe=0, busy=0, keys=0, raw=0, valid=0, FSM=IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame immediately to the reset values. No valid pulse is produced and keys/raw are cleared.
- Timebase: a half-period counter counts 0..HALF_PER-1. Each serial bit is HALF_PER cycles with sclk=0 followed by HALF_PER cycles with sclk=1.
- FSM states: IDLE, SETUP, CMD, WAIT, READ, HOLD.
- IDLE: if start=1, then at that edge go to SETUP with stb=0, busy=1, dio_oe=1, dio_out=0.
- SETUP: stb=0, sclk=1, for HALF_PER cycles, then go to CMD.
- CMD: shift out 8 bits of 0x42, LSB first.
  - dio_out changes on the cycle sclk goes low and is stable through the high phase.
  - After the 8th high phase, go to WAIT.
- WAIT: dio_oe=0, sclk=1, stb=0, for WAIT_CYC cycles, then go to READ.
- READ: 32 bits, dio_oe=0.
  - dio_in is sampled on the cycle sclk transitions 0→1, i.e. the first cycle of each high phase.
  - Bits shift LSB first into raw-shadow bit n, where n = 0..31 in order.
  - After the 32nd high phase, go to HOLD.
- HOLD: stb=1, sclk=1, for HALF_PER cycles. On exit:
  - raw ← shadow.
  - keys ← decoded shadow.
  - valid=1 for exactly one cycle.
  - busy=0 in that same cycle; FSM returns to IDLE.
- Decode: for i = 0..3, keys[i] = byte_i[0] and keys[i+4] = byte_i[4]. Other scan bits are ignored for keys but kept in raw.
- Latency: with start accepted at edge E0, valid is high in the cycle beginning E0 + 82*HALF_PER + WAIT_CYC. This latency is fixed and independent of data.
- start during busy (including the HOLD cycle) is dropped, not queued. start in the same cycle as valid is also dropped; the next accepted start is the one seen in IDLE.
- keys and raw hold their values between scans and are never partially updated.
- stb is never low while FSM is IDLE. sclk never toggles while stb=1.

Test Plan (HALF_PER=2, WAIT_CYC=4 unless noted):
- Reset then idle 50 cycles → stb=1, sclk=1, dio_oe=0, busy=0, keys=0x00, valid never 1.
- Single start, TM1638 model returns 0x01,0x10,0x00,0x11:
  - dio_out at the 8 command rising edges reads 0,1,0,0,0,0,1,0.
  - Exactly 40 sclk rising edges occur while stb=0.
  - valid occurs at E0+168; keys=0xA9; raw=0x11001001.
- Model returns all 0xFF → keys=0xFF, raw=0xFFFFFFFF. Follow-up scan returning all 0x00 → keys=0x00 and valid is pulsed again.
- Extra start pulses at E0+5, E0+100 and at the valid cycle → only one frame, one valid pulse. busy stays high continuously from E0+1 to valid.
- Reset asserted at E0+60 (during READ) → next cycle stb=1, sclk=1, dio_oe=0, busy=0, keys=0. A new start produces a full, correct frame.
- dio_oe check on every frame: 1 only during SETUP/CMD, 0 from WAIT through HOLD. Repeat the directed case with HALF_PER=25, WAIT_CYC=100 → valid at E0+2150.

Source files
------------

// File: rtl/tm1638_key_reader.sv
// TM1638 key scanner: one start pulse runs a full STB/SCLK/DIO read-key frame
// and publishes the 8 decoded buttons plus the raw 4-byte scan with a valid strobe.
`timescale 1ns/1ps
module tm1638_key_reader #(
    parameter int HALF_PER = 25,
    parameter int WAIT_CYC = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dio_in,
    output logic        stb,
    output logic        sclk,
    output logic        dio_out,
    output logic        dio_oe,
    output logic        busy,
    output logic [7:0]  keys,
    output logic [31:0] raw,
    output logic        valid
);

    localparam int HW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
    localparam int WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [7:0] CMD_READ = 8'h42;

    typedef enum logic [2:0] {IDLE, SETUP, CMD, WAIT, READ, HOLD} state_t;

    state_t        state, state_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [4:0]    bcnt, bcnt_n;
    logic          phase, phase_n;   // 0: sclk-low half of a bit, 1: sclk-high half
    logic [31:0]   shadow, shadow_n;
    logic          stb_n, sclk_n, dio_out_n, dio_oe_n, busy_n, valid_n;
    logic [7:0]    keys_n;
    logic [31:0]   raw_n;
    logic          half_done;

    assign half_done = (hcnt == HW'(HALF_PER - 1));

    // Button S(i+1) is bit 0 of byte i for i<4, bit 4 of byte i-4 otherwise.
    function automatic logic [7:0] decode(input logic [31:0] s);
        logic [7:0] k;
        k = '0;
        for (int i = 0; i < 4; i++) begin
            k[i]     = s[8*i];
            k[i + 4] = s[8*i + 4];
        end
        return k;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            hcnt    <= '0;
            wcnt    <= '0;
            bcnt    <= '0;
            phase   <= 1'b0;
            shadow  <= '0;
            stb     <= 1'b1;
            sclk    <= 1'b1;
            dio_out <= 1'b1;
            dio_oe  <= 1'b0;
            busy    <= 1'b0;
            keys    <= '0;
            raw     <= '0;
            valid   <= 1'b0;
        end else begin
            state   <= state_n;
            hcnt    <= hcnt_n;
            wcnt    <= wcnt_n;
            bcnt    <= bcnt_n;
            phase   <= phase_n;
            shadow  <= shadow_n;
            stb     <= stb_n;
            sclk    <= sclk_n;
            dio_out <= dio_out_n;
            dio_oe  <= dio_oe_n;
            busy    <= busy_n;
            keys    <= keys_n;
            raw     <= raw_n;
            valid   <= valid_n;
        end
    end

    always_comb begin
        state_n   = state;
        hcnt_n    = hcnt;
        wcnt_n    = wcnt;
        bcnt_n    = bcnt;
        phase_n   = phase;
        shadow_n  = shadow;
        stb_n     = stb;
        sclk_n    = sclk;
        dio_out_n = dio_out;
        dio_oe_n  = dio_oe;
        busy_n    = busy;
        keys_n    = keys;
        raw_n     = raw;
        valid_n   = 1'b0;

        case (state)
            IDLE: begin
                // valid marks the cycle we just left HOLD; a start here is dropped
                if (start && !valid) begin
                    state_n   = SETUP;
                    hcnt_n    = '0;
                    stb_n     = 1'b0;
                    sclk_n    = 1'b1;
                    busy_n    = 1'b1;
                    dio_oe_n  = 1'b1;
                    dio_out_n = 1'b0;
                end
            end

            SETUP: begin
                if (half_done) begin
                    state_n   = CMD;
                    hcnt_n    = '0;
                    bcnt_n    = '0;
                    phase_n   = 1'b0;
                    sclk_n    = 1'b0;
                    dio_out_n = CMD_READ[0];
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end

            CMD: begin
                if (!half_done) begin
                    hcnt_n = hcnt + 1'b1;
                end else begin
                    hcnt_n = '0;
                    if (!phase) begin
                        phase_n = 1'b1;
                        sclk_n  = 1'b1;
                    end else if (bcnt == 5'd7) begin
                        state_n   = WAIT;
                        wcnt_n    = '0;
                        dio_oe_n  = 1'b0;
                        dio_out_n = 1'b1;
                    end else begin
                        bcnt_n    = bcnt + 5'd1;
                        phase_n   = 1'b0;
                        sclk_n    = 1'b0;
                        dio_out_n = CMD_READ[bcnt[2:0] + 3'd1];
                    end
                end
            end

            WAIT: begin
                if (wcnt == WW'(WAIT_CYC - 1)) begin
                    state_n = READ;
                    hcnt_n  = '0;
                    bcnt_n  = '0;
                    phase_n = 1'b0;
                    sclk_n  = 1'b0;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                end
            end

            READ: begin
                // capture on the first cycle of each high half
                if (phase && hcnt == '0)
                    shadow_n[bcnt] = dio_in;
                if (!half_done) begin
                    hcnt_n = hcnt + 1'b1;
                end else begin
                    hcnt_n = '0;
                    if (!phase) begin
                        phase_n = 1'b1;
                        sclk_n  = 1'b1;
                    end else if (bcnt == 5'd31) begin
                        state_n = HOLD;
                        stb_n   = 1'b1;
                    end else begin
                        bcnt_n  = bcnt + 5'd1;
                        phase_n = 1'b0;
                        sclk_n  = 1'b0;
                    end
                end
            end

            HOLD: begin
                if (half_done) begin
                    state_n = IDLE;
                    hcnt_n  = '0;
                    raw_n   = shadow;
                    keys_n  = decode(shadow);
                    valid_n = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule
